// File: rtl/ctrl_uart_rx.sv
// ctrl_uart_rx: UART control-port receiver that feeds the LFO.
// It decodes framed register writes from the control-panel poller, holds the
// wave type, frequency and pulse width as registered outputs, and strobes
// upd/err for one cycle on each commit or error.
// Optional feature macro: CTRL_RX_CHECKSUM_EN. When it is defined, frames are
// 4 bytes (sync, header, data low, XOR checksum). When it is not defined,
// frames are 3 bytes and commit on the data-low byte.
module ctrl_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 208,
  parameter int unsigned TIMEOUT_CLKS = 24000,
  parameter logic [9:0]  PW_RESET     = 10'd512
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [1:0] lfo_wave_type,
  output logic [9:0] lfo_frequency,
  output logic [9:0] lfo_pulse_width,
  output logic       upd,
  output logic [1:0] upd_addr,
  output logic       err
);

  localparam int unsigned BIT_CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned TMO_CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [BIT_CW-1:0] BIT_LAST  = BIT_CW'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CW-1:0] HALF_LAST = BIT_CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_CW-1:0] BIT_ONE   = BIT_CW'(1);
  localparam logic [TMO_CW-1:0] TMO_LAST  = TMO_CW'(TIMEOUT_CLKS - 1);
  localparam logic [TMO_CW-1:0] TMO_ONE   = TMO_CW'(1);
  localparam logic [7:0]        SYNC_BYTE = 8'h5A;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    P_SYNC = 2'd0,
    P_HDR  = 2'd1,
`ifdef CTRL_RX_CHECKSUM_EN
    P_LO   = 2'd2,
    P_CHK  = 2'd3
`else
    P_LO   = 2'd2
`endif
  } p_state_e;

`ifdef CTRL_RX_CHECKSUM_EN
  // Checksum byte expected for a given header and data-low byte.
  function automatic logic [7:0] frame_chk(input logic [7:0] hdr, input logic [7:0] lo);
    frame_chk = hdr ^ lo;
  endfunction
`endif

  // Synchronizer
  logic        rx_meta_q, rx_meta_d;
  logic        rxs_q, rxs_d;
  // Bit receiver
  rx_state_e   rx_state_q, rx_state_d;
  logic [BIT_CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        wait_high_q, wait_high_d;
  logic        byte_stb_q, byte_stb_d;
  logic [7:0]  byte_q, byte_d;
  logic        frm_err_s;
  // Parser
  p_state_e    p_state_q, p_state_d;
  logic [3:0]  hdr_addr_q, hdr_addr_d;
  logic [1:0]  hdr_dhi_q, hdr_dhi_d;
`ifdef CTRL_RX_CHECKSUM_EN
  logic [7:0]  lo_q, lo_d;
`endif
  logic [TMO_CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic        cm_pend_q, cm_pend_d;
  logic [3:0]  cm_addr_q, cm_addr_d;
  logic [9:0]  cm_data_q, cm_data_d;
  // Outputs
  logic [1:0]  wave_q, wave_d;
  logic [9:0]  freq_q, freq_d;
  logic [9:0]  pw_q, pw_d;
  logic        upd_q, upd_d;
  logic [1:0]  upd_addr_q, upd_addr_d;
  logic        err_q, err_d;

  // Two-flop synchronizer input stage for the asynchronous rx line.
  always_comb begin
    rx_meta_d = rx;
    rxs_d     = rx_meta_q;
  end

  // Bit receiver: start detection, mid-bit sampling, stop-bit check.
  always_comb begin
    rx_state_d  = rx_state_q;
    bit_cnt_d   = bit_cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    wait_high_d = wait_high_q;
    byte_stb_d  = 1'b0;
    byte_d      = byte_q;
    frm_err_s   = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        bit_idx_d = 3'd0;
        if (wait_high_q) begin
          // After a framing error the line must return high before a new start.
          if (rxs_q) begin
            wait_high_d = 1'b0;
          end else begin
            wait_high_d = 1'b1;
          end
        end else if (!rxs_q) begin
          rx_state_d = S_START;
        end else begin
          rx_state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_cnt_q == HALF_LAST) begin
          bit_cnt_d = '0;
          if (rxs_q) begin
            rx_state_d = S_IDLE;  // false start, silently ignored
          end else begin
            rx_state_d = S_DATA;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_ONE;
        end
      end
      S_DATA: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          shreg_d   = {rxs_q, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            rx_state_d = S_STOP;
          end else begin
            rx_state_d = S_DATA;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_ONE;
        end
      end
      S_STOP: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d  = '0;
          rx_state_d = S_IDLE;
          if (rxs_q) begin
            byte_stb_d = 1'b1;
            byte_d     = shreg_q;
          end else begin
            frm_err_s   = 1'b1;
            wait_high_d = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_ONE;
        end
      end
      default: begin
        rx_state_d = S_IDLE;
        bit_cnt_d  = '0;
      end
    endcase
  end

  // Frame parser and inter-byte timeout; framing errors win over timeouts.
  always_comb begin
    p_state_d  = p_state_q;
    hdr_addr_d = hdr_addr_q;
    hdr_dhi_d  = hdr_dhi_q;
`ifdef CTRL_RX_CHECKSUM_EN
    lo_d       = lo_q;
`endif
    tmo_cnt_d  = tmo_cnt_q;
    cm_pend_d  = 1'b0;
    cm_addr_d  = cm_addr_q;
    cm_data_d  = cm_data_q;
    err_d      = 1'b0;
    if (frm_err_s) begin
      p_state_d = P_SYNC;
      err_d     = 1'b1;
      tmo_cnt_d = '0;
    end else if (byte_stb_q) begin
      tmo_cnt_d = '0;
      case (p_state_q)
        P_SYNC: begin
          if (byte_q == SYNC_BYTE) begin
            p_state_d = P_HDR;
          end else begin
            p_state_d = P_SYNC;
          end
        end
        P_HDR: begin
          if (byte_q[3:2] != 2'b00) begin
            err_d     = 1'b1;
            p_state_d = P_SYNC;
          end else begin
            hdr_addr_d = byte_q[7:4];
            hdr_dhi_d  = byte_q[1:0];
            p_state_d  = P_LO;
          end
        end
`ifdef CTRL_RX_CHECKSUM_EN
        P_LO: begin
          lo_d      = byte_q;
          p_state_d = P_CHK;
        end
        P_CHK: begin
          p_state_d = P_SYNC;
          if (byte_q == frame_chk({hdr_addr_q, 2'b00, hdr_dhi_q}, lo_q)) begin
            cm_pend_d = 1'b1;
            cm_addr_d = hdr_addr_q;
            cm_data_d = {hdr_dhi_q, lo_q};
          end else begin
            err_d = 1'b1;
          end
        end
`else
        P_LO: begin
          p_state_d = P_SYNC;
          cm_pend_d = 1'b1;
          cm_addr_d = hdr_addr_q;
          cm_data_d = {hdr_dhi_q, byte_q};
        end
`endif
        default: begin
          p_state_d = P_SYNC;
        end
      endcase
    end else if (p_state_q == P_SYNC) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q == TMO_LAST) begin
      err_d     = 1'b1;
      p_state_d = P_SYNC;
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TMO_ONE;
    end
  end

  // Commit stage: one cycle after the parser accepts a frame, update the target register.
  always_comb begin
    wave_d     = wave_q;
    freq_d     = freq_q;
    pw_d       = pw_q;
    upd_d      = 1'b0;
    upd_addr_d = upd_addr_q;
    if (cm_pend_q) begin
      case (cm_addr_q)
        4'd0: begin
          wave_d     = cm_data_q[1:0];
          upd_d      = 1'b1;
          upd_addr_d = 2'd0;
        end
        4'd1: begin
          freq_d     = cm_data_q;
          upd_d      = 1'b1;
          upd_addr_d = 2'd1;
        end
        4'd2: begin
          pw_d       = cm_data_q;
          upd_d      = 1'b1;
          upd_addr_d = 2'd2;
        end
        default: begin
          upd_d = 1'b0;  // unmapped address: frame consumed, nothing written
        end
      endcase
    end else begin
      upd_d = 1'b0;
    end
  end

  // State register for all stages with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      rx_state_q  <= S_IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'd0;
      wait_high_q <= 1'b0;
      byte_stb_q  <= 1'b0;
      byte_q      <= 8'd0;
      p_state_q   <= P_SYNC;
      hdr_addr_q  <= 4'd0;
      hdr_dhi_q   <= 2'd0;
`ifdef CTRL_RX_CHECKSUM_EN
      lo_q        <= 8'd0;
`endif
      tmo_cnt_q   <= '0;
      cm_pend_q   <= 1'b0;
      cm_addr_q   <= 4'd0;
      cm_data_q   <= 10'd0;
      wave_q      <= 2'd0;
      freq_q      <= 10'd0;
      pw_q        <= PW_RESET;
      upd_q       <= 1'b0;
      upd_addr_q  <= 2'd0;
      err_q       <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rxs_q       <= rxs_d;
      rx_state_q  <= rx_state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      wait_high_q <= wait_high_d;
      byte_stb_q  <= byte_stb_d;
      byte_q      <= byte_d;
      p_state_q   <= p_state_d;
      hdr_addr_q  <= hdr_addr_d;
      hdr_dhi_q   <= hdr_dhi_d;
`ifdef CTRL_RX_CHECKSUM_EN
      lo_q        <= lo_d;
`endif
      tmo_cnt_q   <= tmo_cnt_d;
      cm_pend_q   <= cm_pend_d;
      cm_addr_q   <= cm_addr_d;
      cm_data_q   <= cm_data_d;
      wave_q      <= wave_d;
      freq_q      <= freq_d;
      pw_q        <= pw_d;
      upd_q       <= upd_d;
      upd_addr_q  <= upd_addr_d;
      err_q       <= err_d;
    end
  end

  assign lfo_wave_type   = wave_q;
  assign lfo_frequency   = freq_q;
  assign lfo_pulse_width = pw_q;
  assign upd             = upd_q;
  assign upd_addr        = upd_addr_q;
  assign err             = err_q;

endmodule

// File: tb/tb_ctrl_uart_rx.sv
// Scoreboard bench for ctrl_uart_rx: stimulus pushes the expected upd/err
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_ctrl_uart_rx;

  localparam int BIT  = 48;
  localparam int HALF = BIT / 2;
  localparam int TMO  = 3000;
`ifdef CTRL_RX_CHECKSUM_EN
  localparam int NBYTES = 4;
`else
  localparam int NBYTES = 3;
`endif
  localparam int F_NONE = 0;
  localparam int F_HDR  = 1;
  localparam int F_STOP = 2;
  localparam int F_CHK  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [1:0] wt;
  logic [9:0] fq;
  logic [9:0] pw;
  logic       upd;
  logic [1:0] upd_addr;
  logic       err;

  ctrl_uart_rx #(
    .CLKS_PER_BIT(BIT),
    .TIMEOUT_CLKS(TMO),
    .PW_RESET(10'd512)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .lfo_wave_type(wt),
    .lfo_frequency(fq),
    .lfo_pulse_width(pw),
    .upd(upd),
    .upd_addr(upd_addr),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_err;
    logic [1:0] addr;
    logic [1:0] wt;
    logic [9:0] fq;
    logic [9:0] pw;
  } ev_t;

  ev_t         sb[$];
  ev_t         mon_ev;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_upd_cyc = -1;
  int          last_err_cyc = -1;
  int          last_end = 0;
  logic [1:0]  m_wt;
  logic [9:0]  m_fq;
  logic [9:0]  m_pw;
  logic [21:0] prev_out;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_win(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: every upd/err pulse consumes one expected event.
  always @(negedge clk) begin
    if (!reset) begin
      if ({wt, fq, pw} !== prev_out) chk("change_needs_upd", 32'(upd), 32'd1);
      if (upd === 1'b1) last_upd_cyc = cyc;
      if (err === 1'b1) last_err_cyc = cyc;
      if (upd === 1'b1 || err === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", {30'd0, upd, err}, 32'd0);
        end else begin
          mon_ev = sb.pop_front();
          chk("event_kind", {30'd0, upd, err}, mon_ev.is_err ? 32'd1 : 32'd2);
          if (!mon_ev.is_err) begin
            chk("upd_addr", 32'(upd_addr), 32'(mon_ev.addr));
            chk("wave_type", 32'(wt), 32'(mon_ev.wt));
            chk("frequency", 32'(fq), 32'(mon_ev.fq));
            chk("pulse_width", 32'(pw), 32'(mon_ev.pw));
          end
        end
      end
    end
    prev_out = {wt, fq, pw};
  end

  task automatic push_err();
    ev_t e;
    e.is_err = 1'b1; e.addr = 2'd0; e.wt = 2'd0; e.fq = 10'd0; e.pw = 10'd0;
    sb.push_back(e);
  endtask

  // Reference model: a complete valid frame writes the addressed register.
  task automatic model_commit(input logic [3:0] addr, input logic [9:0] data);
    ev_t e;
    if (addr < 4'd3) begin
      if (addr == 4'd0) m_wt = data[1:0];
      else if (addr == 4'd1) m_fq = data;
      else m_pw = data;
      e.is_err = 1'b0; e.addr = addr[1:0]; e.wt = m_wt; e.fq = m_fq; e.pw = m_pw;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(bad_stop ? 1'b0 : 1'b1);
    last_end = cyc;
  endtask

  task automatic send_frame(input logic [3:0] addr, input logic [9:0] data,
                            input int fault, input int stop_at);
    logic [7:0] b [0:3];
    int n;
    b[0] = 8'h5A;
    b[1] = {addr, 2'b00, data[9:8]};
    b[2] = data[7:0];
    b[3] = b[1] ^ b[2];
    n = NBYTES;
    case (fault)
      F_HDR: begin b[1][3:2] = 2'($urandom_range(1, 3)); n = 2; push_err(); end
      F_STOP: begin n = (stop_at < 0) ? $urandom_range(1, NBYTES) : stop_at + 1; push_err(); end
      F_CHK: begin b[3] = b[3] ^ 8'($urandom_range(1, 255)); push_err(); end
      default: model_commit(addr, data);
    endcase
    for (int i = 0; i < n; i++) begin
      send_byte(b[i], (fault == F_STOP) && (i == n - 1));
      if (i < n - 1) idle($urandom_range(0, HALF));
    end
    if (fault == F_STOP) idle(BIT);
  endtask

  task automatic settle_check();
    idle(8);
    chk("events_drained", sb.size(), 32'd0);
    chk("hold_wave_type", 32'(wt), 32'(m_wt));
    chk("hold_frequency", 32'(fq), 32'(m_fq));
    chk("hold_pulse_width", 32'(pw), 32'(m_pw));
  endtask

  task automatic check_reset_vals();
    chk("rst_wave_type", 32'(wt), 32'd0);
    chk("rst_frequency", 32'(fq), 32'd0);
    chk("rst_pulse_width", 32'(pw), 32'd512);
    chk("rst_upd", 32'(upd), 32'd0);
    chk("rst_upd_addr", 32'(upd_addr), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
  endtask

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: got no finish, expected finish within 150000 cycles");
    $fatal(1);
  end

  initial begin
    int end_h;
    int a;
    int r;
    m_wt = 2'd0; m_fq = 10'd0; m_pw = 10'd512;
    reset = 1'b1; rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_vals();
    idle(10);

    // Good frames: frequency max, then pulse width 100; latency vs last stop bit.
    send_frame(4'd1, 10'd1023, F_NONE, -1);
    chk_win("upd_latency", last_upd_cyc - last_end, -HALF + 3, -HALF + 7);
    settle_check();
    send_frame(4'd2, 10'd100, F_NONE, -1);
    settle_check();

`ifdef CTRL_RX_CHECKSUM_EN
    send_frame(4'd0, 10'h002, F_CHK, -1);
    settle_check();
`endif
    send_frame(4'd1, 10'd5, F_HDR, -1);
    settle_check();

    // Framing error on the data-low byte, then a good wave-type write.
    send_frame(4'd1, 10'h155, F_STOP, 2);
    settle_check();
    send_frame(4'd0, 10'd3, F_NONE, -1);
    settle_check();

    // False start followed by a normal frame.
    rx = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    idle(2 * BIT);
    settle_check();
    send_frame(4'd1, 10'h2A5, F_NONE, -1);
    settle_check();

    // Inter-byte timeout after the header; the late bytes are dropped.
    push_err();
    send_byte(8'h5A, 1'b0);
    send_byte(8'h10, 1'b0);
    end_h = last_end;
    idle(TMO + 1000);
    chk_win("timeout_latency", last_err_cyc - end_h, TMO - HALF + 2, TMO - HALF + 6);
    send_byte(8'hAB, 1'b0);
`ifdef CTRL_RX_CHECKSUM_EN
    send_byte(8'hBB, 1'b0);
`endif
    settle_check();

    // Randomized frames, with faults mixed in.
    for (int k = 0; k < 14; k++) begin
      a = $urandom_range(0, 5);
      if (a > 2) a = $urandom_range(3, 15);
      r = $urandom_range(0, 9);
      if (r < 6) send_frame(4'(a), 10'($urandom_range(0, 1023)), F_NONE, -1);
      else if (r == 6) send_frame(4'(a), 10'($urandom_range(0, 1023)), F_HDR, -1);
      else if (r < 9) send_frame(4'(a), 10'($urandom_range(0, 1023)), F_STOP, -1);
`ifdef CTRL_RX_CHECKSUM_EN
      else send_frame(4'(a), 10'($urandom_range(0, 1023)), F_CHK, -1);
`else
      else send_frame(4'(a), 10'($urandom_range(0, 1023)), F_NONE, -1);
`endif
      if (k % 4 == 0) settle_check();
      else idle($urandom_range(0, BIT));
    end
    settle_check();

    // Reset in the middle of a frame discards it.
    send_byte(8'h5A, 1'b0);
    send_byte(8'h20, 1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rx = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    m_wt = 2'd0; m_fq = 10'd0; m_pw = 10'd512;
    check_reset_vals();
    idle(2 * BIT);
    settle_check();
    send_frame(4'd2, 10'd777, F_NONE, -1);
    settle_check();

    idle(20);
    chk("final_queue_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
